// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYC = 1,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    HALT       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT     = CNT_W'(MEM_TIMEOUT);
  localparam logic [1:0]       LS_LAST     = 2'(LOAD_STALL_CYC - 1);
  localparam bit               MULTI_STALL = (LOAD_STALL_CYC > 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic [1:0]       ls_cnt;
  logic [1:0]       ls_cnt_nxt;
  logic             lu;
  logic             mw;
  logic             run_eval;
  logic             take_redirect;

  // Hazard terms: load-use against the instruction in ID, and a stalled data-memory access.
  always_comb begin
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    mw = mem_req && !mem_ready;
  end

  // Next state and Mealy enables; RUN priority is shared by RUN and by the MEM_WAIT release cycle.
  always_comb begin
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    ifid_flush    = 1'b0;
    idex_en       = 1'b0;
    idex_flush    = 1'b0;
    exmem_en      = 1'b0;
    take_redirect = 1'b0;
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    ls_cnt_nxt    = ls_cnt;
    run_eval      = 1'b0;

    case (state)
      RUN: begin
        if (mw) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end else begin
          run_eval = 1'b1;
        end
      end
      LOAD_STALL: begin
        // EX holds a bubble here, so any redirect seen is spurious and ignored.
        if (!mw) begin
          exmem_en   = 1'b1;
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          if (ls_cnt == LS_LAST) begin
            state_nxt = RUN;
          end else begin
            ls_cnt_nxt = ls_cnt + 2'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          run_eval = 1'b1;
        end else if (wait_cnt == TIMEOUT) begin
          state_nxt = HALT;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = HALT;
      end
    endcase

    if (run_eval) begin
      state_nxt = RUN;
      if (ex_redirect) begin
        // The younger instruction is squashed, so a simultaneous load-use is moot.
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b1;
        idex_en       = 1'b1;
        idex_flush    = 1'b1;
        exmem_en      = 1'b1;
        take_redirect = 1'b1;
      end else if (lu) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        if (MULTI_STALL) begin
          state_nxt  = LOAD_STALL;
          ls_cnt_nxt = 2'd1;
        end
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
      end
    end

    // Everything held off while reset is asserted.
    if (reset) begin
      pc_en         = 1'b0;
      ifid_en       = 1'b0;
      ifid_flush    = 1'b0;
      idex_en       = 1'b0;
      idex_flush    = 1'b0;
      exmem_en      = 1'b0;
      take_redirect = 1'b0;
    end
  end

  assign halted = (state == HALT);

  // State register with its bubble and wait counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      ls_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      ls_cnt   <= ls_cnt_nxt;
    end
  end

  // Saturating count of cycles where the PC was held (HALT cycles excluded).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_en && (state != HALT) && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Saturating count of redirects actually taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt <= '0;
    end else if (take_redirect && (flush_cnt != CNT_MAX)) begin
      flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [6:0]       obs;

  pipeline_hazard_ctrl #(.LOAD_STALL_CYC(2), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, halted}
  assign obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, halted};

  localparam logic [6:0] O_RUN   = 7'b1101010;
  localparam logic [6:0] O_FLUSH = 7'b1111110;
  localparam logic [6:0] O_LU    = 7'b0000110;
  localparam logic [6:0] O_WAIT  = 7'b0000000;
  localparam logic [6:0] O_HALT  = 7'b0000001;
  localparam logic [6:0] M_ALL   = 7'b1111111;
  localparam logic [6:0] M_LU    = 7'b1110111;  // idex_en is moot while idex_flush=1

  typedef struct {
    int         hz;
    bit         red;
    bit         mreq;
    bit         mrdy;
    logic [6:0] val;
    logic [6:0] mask;
  } row_t;

  typedef struct {
    logic [6:0] val;
    logic [6:0] mask;
  } exp_t;

  row_t rows[$];
  exp_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;

  function automatic row_t mk(input int hz, input bit red, input bit mreq, input bit mrdy,
                              input logic [6:0] val);
    row_t r;
    r.hz   = hz;
    r.red  = red;
    r.mreq = mreq;
    r.mrdy = mrdy;
    r.val  = val;
    r.mask = (val == O_LU) ? M_LU : M_ALL;
    return r;
  endfunction

  // hz: 0 idle, 1 rs1 load-use, 2 rs2 load-use, 3 rd=x0 load, 4 rs2 match unused, 5 match but not a load
  task automatic set_inputs(input int hz, input bit red, input bit mreq, input bit mrdy);
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0;
    case (hz)
      1: begin ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd3; id_use_rs2 = 1'b1; end
      2: begin ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; id_rs1 = 5'd2; id_use_rs1 = 1'b1; end
      3: begin ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; id_rs2 = 5'd0; id_use_rs2 = 1'b1; end
      4: begin ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd7; end
      5: begin ex_mem_read = 1'b0; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; end
      default: ;
    endcase
    ex_redirect = red;
    mem_req     = mreq;
    mem_ready   = mrdy;
  endtask

  task automatic apply(input row_t r);
    exp_t e;
    @(posedge clk); #1;
    set_inputs(r.hz, r.red, r.mreq, r.mrdy);
    e.val  = r.val;
    e.mask = r.mask;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    set_inputs(0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_inputs(0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_inputs(1, 1, 1, 0);
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (obs !== 7'b0) begin n_err++; $display("FAIL reset outs: got %b want %b", obs, 7'b0); end
    n_chk++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      n_err++; $display("FAIL reset counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    do_reset();
  endtask

  task automatic test_no_hazard();
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) rows.push_back(mk(0, 0, 0, 0, O_RUN));
    rows.push_back(mk(5, 0, 0, 0, O_RUN));
    rows.push_back(mk(0, 0, 1, 1, O_RUN));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_chk++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin n_err++; $display("FAIL no_hazard row %0d: got %b want %b", i, obs, e.val); end
    end
    rows.delete();
    idle_cycle();
    n_chk++;
    if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL no_hazard stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    exp_t e;
    do_reset();
    rows.push_back(mk(1, 0, 0, 0, O_LU));
    rows.push_back(mk(0, 0, 0, 0, O_LU));
    rows.push_back(mk(0, 0, 0, 0, O_RUN));
    rows.push_back(mk(3, 0, 0, 0, O_RUN));
    rows.push_back(mk(0, 0, 0, 0, O_RUN));
    rows.push_back(mk(2, 0, 0, 0, O_LU));
    rows.push_back(mk(0, 0, 0, 0, O_LU));
    rows.push_back(mk(4, 0, 0, 0, O_RUN));
    rows.push_back(mk(0, 0, 0, 0, O_RUN));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_chk++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin n_err++; $display("FAIL load_use row %0d: got %b want %b", i, obs, e.val); end
    end
    rows.delete();
    idle_cycle();
    n_chk++;
    if (stall_cnt !== 4'd4) begin n_err++; $display("FAIL load_use stall_cnt: got %0d want 4", stall_cnt); end
  endtask

  task automatic test_redirect();
    exp_t e;
    do_reset();
    rows.push_back(mk(1, 1, 0, 0, O_FLUSH));
    rows.push_back(mk(0, 0, 0, 0, O_RUN));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_chk++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin n_err++; $display("FAIL redirect row %0d: got %b want %b", i, obs, e.val); end
    end
    rows.delete();
    idle_cycle();
    n_chk++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      n_err++; $display("FAIL redirect counters: got flush %0d stall %0d want 1/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    rows.push_back(mk(0, 1, 0, 0, O_FLUSH));
    rows.push_back(mk(1, 0, 0, 0, O_LU));
    rows.push_back(mk(0, 1, 0, 0, O_LU));
    rows.push_back(mk(0, 1, 0, 0, O_FLUSH));
    rows.push_back(mk(2, 1, 0, 0, O_FLUSH));
    rows.push_back(mk(0, 0, 0, 0, O_RUN));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_chk++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin n_err++; $display("FAIL back_to_back row %0d: got %b want %b", i, obs, e.val); end
    end
    rows.delete();
    idle_cycle();
    n_chk++;
    if (flush_cnt !== 4'd3 || stall_cnt !== 4'd2) begin
      n_err++; $display("FAIL back_to_back counters: got flush %0d stall %0d want 3/2", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    do_reset();
    for (int i = 0; i < 3; i++) rows.push_back(mk(0, 0, 1, 0, O_WAIT));
    rows.push_back(mk(0, 0, 1, 1, O_RUN));
    rows.push_back(mk(0, 0, 0, 0, O_RUN));
    rows.push_back(mk(0, 1, 1, 0, O_WAIT));
    rows.push_back(mk(0, 1, 1, 1, O_FLUSH));
    rows.push_back(mk(0, 0, 0, 0, O_RUN));
    rows.push_back(mk(1, 0, 1, 0, O_WAIT));
    rows.push_back(mk(1, 0, 1, 1, O_LU));
    rows.push_back(mk(0, 0, 0, 0, O_LU));
    rows.push_back(mk(0, 0, 0, 0, O_RUN));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_chk++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin n_err++; $display("FAIL mem_wait row %0d: got %b want %b", i, obs, e.val); end
      if (i == 4) begin
        n_chk++;
        if (stall_cnt !== 4'd3) begin n_err++; $display("FAIL mem_wait stall_cnt: got %0d want 3", stall_cnt); end
      end
    end
    rows.delete();
    idle_cycle();
    n_chk++;
    if (stall_cnt !== 4'd7 || flush_cnt !== 4'd1) begin
      n_err++; $display("FAIL mem_wait counters: got stall %0d flush %0d want 7/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    do_reset();
    // ready coincides with the timeout count: release wins
    for (int i = 0; i < 4; i++) rows.push_back(mk(0, 0, 1, 0, O_WAIT));
    rows.push_back(mk(0, 0, 1, 1, O_RUN));
    rows.push_back(mk(0, 0, 0, 0, O_RUN));
    // ready never comes: HALT after four cycles in MEM_WAIT
    for (int i = 0; i < 5; i++) rows.push_back(mk(0, 0, 1, 0, O_WAIT));
    rows.push_back(mk(0, 0, 0, 0, O_HALT));
    rows.push_back(mk(0, 0, 1, 1, O_HALT));
    rows.push_back(mk(1, 1, 0, 0, O_HALT));
    rows.push_back(mk(0, 0, 0, 0, O_HALT));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_chk++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin n_err++; $display("FAIL timeout row %0d: got %b want %b", i, obs, e.val); end
    end
    rows.delete();
    idle_cycle();
    n_chk++;
    if (stall_cnt !== 4'd9 || halted !== 1'b1) begin
      n_err++; $display("FAIL timeout halt: got stall %0d halted %b want 9/1", stall_cnt, halted);
    end
    do_reset();
    @(negedge clk);
    n_chk++;
    if (obs !== O_RUN || stall_cnt !== 4'd0) begin
      n_err++; $display("FAIL timeout after reset: got %b stall %0d want %b stall 0", obs, stall_cnt, O_RUN);
    end
  endtask

  task automatic test_stall_wait_reset();
    exp_t e;
    do_reset();
    rows.push_back(mk(1, 0, 0, 0, O_LU));
    rows.push_back(mk(0, 0, 1, 0, O_WAIT));
    rows.push_back(mk(0, 0, 1, 0, O_WAIT));
    rows.push_back(mk(0, 1, 0, 0, O_LU));
    rows.push_back(mk(0, 0, 0, 0, O_RUN));
    rows.push_back(mk(0, 0, 1, 0, O_WAIT));
    rows.push_back(mk(0, 0, 1, 0, O_WAIT));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_chk++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin n_err++; $display("FAIL stall_wait row %0d: got %b want %b", i, obs, e.val); end
      if (i == 4) begin
        n_chk++;
        if (stall_cnt !== 4'd4 || flush_cnt !== 4'd0) begin
          n_err++; $display("FAIL stall_wait counters: got stall %0d flush %0d want 4/0", stall_cnt, flush_cnt);
        end
      end
    end
    rows.delete();
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (obs !== 7'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      n_err++; $display("FAIL async reset: got %b stall %0d flush %0d want 0000000 0 0", obs, stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (obs !== O_WAIT) begin n_err++; $display("FAIL redetect after reset: got %b want %b", obs, O_WAIT); end
    rows.push_back(mk(0, 0, 1, 1, O_RUN));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_chk++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin n_err++; $display("FAIL post_reset row %0d: got %b want %b", i, obs, e.val); end
    end
    rows.delete();
    idle_cycle();
    n_chk++;
    if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL post_reset stall_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    for (int i = 0; i < 20; i++) rows.push_back(mk(1, 0, 0, 0, O_LU));
    for (int i = 0; i < 20; i++) rows.push_back(mk(0, 1, 0, 0, O_FLUSH));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = sb.pop_front();
      n_chk++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin n_err++; $display("FAIL saturation row %0d: got %b want %b", i, obs, e.val); end
    end
    rows.delete();
    idle_cycle();
    n_chk++;
    if (stall_cnt !== 4'd15 || flush_cnt !== 4'd15) begin
      n_err++; $display("FAIL saturation counters: got stall %0d flush %0d want 15/15", stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    set_inputs(0, 0, 0, 0);
    test_reset();
    test_no_hazard();
    test_load_use();
    test_redirect();
    test_back_to_back();
    test_mem_wait();
    test_timeout();
    test_stall_wait_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
